mac_sched: RTL

Scheduler that shares one gated-clock multiply-accumulate unit between NUM_REQ requesters.
- Arbitrates round-robin and grants the MAC to one requester for a whole job: a clear, then `len` A/B operand beats.
- Drives the MAC's clr/en/A/B and waits out its two-stage pipeline (product register, then accumulator).
- Captures the accumulated sum and returns it tagged with the requester ID.
- Sits between client blocks and the MAC; it is the only driver of the MAC control inputs.

---
 rtl/mac_sched_pkg.sv | 12 +
 rtl/mac_sched_if.sv | 43 ++++
 rtl/mac_sched_rr_arbiter.sv | 26 ++
 rtl/mac_sched.sv | 114 +++++++++++
 4 files changed

// File: rtl/mac_sched_pkg.sv
// Shared types and constants for the MAC scheduler.
package mac_sched_pkg;
  localparam int OP_W      = 8;
  localparam int DEF_ACC_W = 64;
  localparam int DEF_LEN_W = 8;

  typedef enum logic [2:0] {IDLE, CLR, RUN, DRAIN, CAPT} state_e;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/mac_sched_if.sv
// Requester / MAC / result bundle for mac_sched. err exists only with MAC_SCHED_TIMEOUT_EN.
interface mac_sched_if import mac_sched_pkg::*; #(
  parameter int NUM_REQ = 2,
  parameter int LEN_W   = DEF_LEN_W,
  parameter int ACC_W   = DEF_ACC_W
);
  localparam int ID_W = idx_w(NUM_REQ);

  logic [NUM_REQ-1:0]            req;
  logic [NUM_REQ-1:0][LEN_W-1:0] len;
  logic [NUM_REQ-1:0]            gnt;
  logic [NUM_REQ-1:0]            vld;
  logic [NUM_REQ-1:0][OP_W-1:0]  a_in;
  logic [NUM_REQ-1:0][OP_W-1:0]  b_in;
  logic [NUM_REQ-1:0]            rdy;
  logic                          mac_clr;
  logic                          mac_en;
  logic [OP_W-1:0]               mac_A;
  logic [OP_W-1:0]               mac_B;
  logic [ACC_W-1:0]              mac_accum;
  logic                          done;
  logic [ID_W-1:0]               done_id;
  logic [ACC_W-1:0]              result;
`ifdef MAC_SCHED_TIMEOUT_EN
  logic                          err;
`endif

  modport master (
    input  req, len, vld, a_in, b_in, mac_accum,
    output gnt, rdy, mac_clr, mac_en, mac_A, mac_B, done, done_id, result
`ifdef MAC_SCHED_TIMEOUT_EN
    , output err
`endif
  );

  modport slave (
    output req, len, vld, a_in, b_in, mac_accum,
    input  gnt, rdy, mac_clr, mac_en, mac_A, mac_B, done, done_id, result
`ifdef MAC_SCHED_TIMEOUT_EN
    , input err
`endif
  );
endinterface

// File: rtl/mac_sched_rr_arbiter.sv
// Combinational round-robin pick: first set req at or after ptr, wrapping.
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [ID_W-1:0]    idx,
  output logic               any
);
  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    // Scan from the far end so the nearest hit to ptr is the one that sticks.
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req[(int'(ptr) + i) % NUM_REQ]) begin
        gnt = '0;
        gnt[(int'(ptr) + i) % NUM_REQ] = 1'b1;
        idx = ID_W'((int'(ptr) + i) % NUM_REQ);
        any = 1'b1;
      end
    end
  end
endmodule

// File: rtl/mac_sched.sv
// Round-robin job scheduler for one shared two-stage MAC (clear, len beats, drain, capture).
// Optional beat-stall abort with err output: define MAC_SCHED_TIMEOUT_EN.
module mac_sched import mac_sched_pkg::*; #(
  parameter int NUM_REQ = 2,
  parameter int LEN_W   = DEF_LEN_W,
  parameter int ACC_W   = DEF_ACC_W
`ifdef MAC_SCHED_TIMEOUT_EN
  , parameter int TO_CYC = 255
`endif
) (
  input  logic       clk,
  input  logic       rst_n,
  mac_sched_if.master bus
);
  localparam int ID_W = idx_w(NUM_REQ);

  state_e             state, state_nxt;
  logic [ID_W-1:0]    ptr, sel;
  logic [LEN_W-1:0]   cnt;
  logic [NUM_REQ-1:0] arb_gnt;
  logic [ID_W-1:0]    arb_idx;
  logic               arb_any;
  logic               beat;
  logic               abort;
  logic               arb_ok;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_arb (
    .req (bus.req),
    .ptr (ptr),
    .gnt (arb_gnt),
    .idx (arb_idx),
    .any (arb_any)
  );

  assign beat   = (state == RUN) && bus.vld[sel];
  // CAPT re-arbitrates directly so back-to-back jobs skip IDLE.
  assign arb_ok = ((state == IDLE) || (state == CAPT)) && arb_any;

`ifdef MAC_SCHED_TIMEOUT_EN
  localparam int ST_W = $clog2(TO_CYC + 1);
  logic [ST_W-1:0] stall;
  logic            aborted;

  assign abort = (state == RUN) && !beat && (stall == ST_W'(TO_CYC - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall   <= '0;
      aborted <= 1'b0;
      bus.err <= 1'b0;
    end else begin
      stall   <= ((state != RUN) || beat) ? '0 : stall + 1'b1;
      if (state == CLR) aborted <= 1'b0;
      else if (abort)   aborted <= 1'b1;
      bus.err <= (state == CAPT) && aborted;
    end
  end
`else
  assign abort = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (arb_any) state_nxt = CLR;
      CLR:     state_nxt = (cnt != '0) ? RUN : CAPT;
      RUN:     if ((beat && cnt == LEN_W'(1)) || abort) state_nxt = DRAIN;
      DRAIN:   state_nxt = CAPT;
      CAPT:    state_nxt = arb_any ? CLR : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Operand mux is zeroed outside RUN to keep the MAC inputs quiet.
  always_comb begin
    bus.rdy = '0;
    if (state == RUN) bus.rdy[sel] = 1'b1;
    bus.mac_clr = (state == CLR);
    bus.mac_en  = beat;
    bus.mac_A   = (state == RUN) ? bus.a_in[sel] : '0;
    bus.mac_B   = (state == RUN) ? bus.b_in[sel] : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr         <= '0;
      sel         <= '0;
      cnt         <= '0;
      bus.gnt     <= '0;
      bus.done    <= 1'b0;
      bus.done_id <= '0;
      bus.result  <= '0;
    end else begin
      bus.done <= (state == CAPT);
      if (state == CAPT) begin
        bus.result  <= bus.mac_accum;
        bus.done_id <= sel;
        bus.gnt     <= '0;
      end
      if (arb_ok) begin
        bus.gnt <= arb_gnt;
        sel     <= arb_idx;
        cnt     <= bus.len[arb_idx];
        ptr     <= (arb_idx == ID_W'(NUM_REQ - 1)) ? '0 : arb_idx + 1'b1;
      end
      if (beat) cnt <= cnt - 1'b1;
    end
  end
endmodule
